// File: rtl/mor1kx_tlb_reload_arbiter_if.sv
// mor1kx_tlb_reload_arbiter_if: IMMU/DMMU reload channels plus the shared single-word reload bus
// slave  : arbiter side (takes walker requests and bus responses, drives walker responses and bus request)
// master : environment side (walkers and reload bus)
interface mor1kx_tlb_reload_arbiter_if #(
    parameter int OW = 32
);
    logic          immu_reload_req_i;
    logic [OW-1:0] immu_reload_addr_i;
    logic          immu_reload_ack_o;
    logic [OW-1:0] immu_reload_data_o;
    logic          immu_reload_err_o;
    logic          dmmu_reload_req_i;
    logic [OW-1:0] dmmu_reload_addr_i;
    logic          dmmu_reload_ack_o;
    logic [OW-1:0] dmmu_reload_data_o;
    logic          dmmu_reload_err_o;
    logic          reload_bus_req_o;
    logic [OW-1:0] reload_bus_adr_o;
    logic          reload_bus_ack_i;
    logic          reload_bus_err_i;
    logic [OW-1:0] reload_bus_dat_i;
    logic          busy_o;
    logic          owner_o;

    modport slave (
        input  immu_reload_req_i, immu_reload_addr_i,
        input  dmmu_reload_req_i, dmmu_reload_addr_i,
        input  reload_bus_ack_i, reload_bus_err_i, reload_bus_dat_i,
        output immu_reload_ack_o, immu_reload_data_o, immu_reload_err_o,
        output dmmu_reload_ack_o, dmmu_reload_data_o, dmmu_reload_err_o,
        output reload_bus_req_o, reload_bus_adr_o, busy_o, owner_o
    );

    modport master (
        output immu_reload_req_i, immu_reload_addr_i,
        output dmmu_reload_req_i, dmmu_reload_addr_i,
        output reload_bus_ack_i, reload_bus_err_i, reload_bus_dat_i,
        input  immu_reload_ack_o, immu_reload_data_o, immu_reload_err_o,
        input  dmmu_reload_ack_o, dmmu_reload_data_o, dmmu_reload_err_o,
        input  reload_bus_req_o, reload_bus_adr_o, busy_o, owner_o
    );
endinterface

// File: rtl/mor1kx_tlb_reload_arbiter.sv
// mor1kx_tlb_reload_arbiter: shares one reload read port between the IMMU and DMMU page walkers
// clk, rst : clock and synchronous active-high reset
// rl       : slave modport with both walker req/addr/ack/data/err channels, the reload bus, busy_o and owner_o
module mor1kx_tlb_reload_arbiter #(
    parameter int    OPTION_OPERAND_WIDTH   = 32,
    parameter string FEATURE_RELOAD_TIMEOUT = "ENABLED",
    parameter int    OPTION_TIMEOUT_WIDTH   = 10
) (
    input logic                        clk,
    input logic                        rst,
    mor1kx_tlb_reload_arbiter_if.slave rl
);
    localparam bit WD_EN = (FEATURE_RELOAD_TIMEOUT == "ENABLED");

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, CHECK} state_t;

    state_t                          state;
    logic                            last;
    logic [OPTION_TIMEOUT_WIDTH-1:0] wd;

    logic                            own_req;
    logic [OPTION_OPERAND_WIDTH-1:0] own_adr;
    logic                            dsel;
    logic [OPTION_TIMEOUT_WIDTH-1:0] wd_nxt;
    logic                            wd_exp;
    logic                            done;
    logic                            good;

    always_comb begin
        own_req = rl.owner_o ? rl.dmmu_reload_req_i : rl.immu_reload_req_i;
        own_adr = rl.owner_o ? rl.dmmu_reload_addr_i : rl.immu_reload_addr_i;
        // DMMU wins only when IMMU is idle or IMMU was the last walker served
        dsel    = rl.dmmu_reload_req_i && (!rl.immu_reload_req_i || !last);
        // expiry fires on the (2**W-1)th ACCESS cycle, so the bus request is high exactly that long
        wd_nxt  = wd + 1'b1;
        wd_exp  = WD_EN && (&wd_nxt);
        done    = rl.reload_bus_err_i || rl.reload_bus_ack_i || wd_exp;
        good    = rl.reload_bus_ack_i && !rl.reload_bus_err_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            last                  <= 1'b1;
            wd                    <= '0;
            rl.immu_reload_ack_o  <= 1'b0;
            rl.immu_reload_data_o <= '0;
            rl.immu_reload_err_o  <= 1'b0;
            rl.dmmu_reload_ack_o  <= 1'b0;
            rl.dmmu_reload_data_o <= '0;
            rl.dmmu_reload_err_o  <= 1'b0;
            rl.reload_bus_req_o   <= 1'b0;
            rl.reload_bus_adr_o   <= '0;
            rl.busy_o             <= 1'b0;
            rl.owner_o            <= 1'b0;
        end else begin
            rl.immu_reload_ack_o <= 1'b0;
            rl.dmmu_reload_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (rl.immu_reload_req_i || rl.dmmu_reload_req_i) begin
                        rl.owner_o          <= dsel;
                        rl.reload_bus_adr_o <= dsel ? rl.dmmu_reload_addr_i : rl.immu_reload_addr_i;
                        rl.reload_bus_req_o <= 1'b1;
                        rl.busy_o           <= 1'b1;
                        state               <= ACCESS;
                    end
                end
                ACCESS: begin
                    wd <= wd_nxt;
                    if (done) begin
                        rl.reload_bus_req_o  <= 1'b0;
                        rl.immu_reload_ack_o <= !rl.owner_o;
                        rl.dmmu_reload_ack_o <= rl.owner_o;
                        // a timeout or bus error reports err and leaves the data register alone
                        if (rl.owner_o) begin
                            rl.dmmu_reload_err_o <= !good;
                            if (good)
                                rl.dmmu_reload_data_o <= rl.reload_bus_dat_i;
                        end else begin
                            rl.immu_reload_err_o <= !good;
                            if (good)
                                rl.immu_reload_data_o <= rl.reload_bus_dat_i;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    wd    <= '0;
                    state <= CHECK;
                end
                default: begin
                    // the grant stays locked to the owner until it drops req
                    if (own_req) begin
                        rl.reload_bus_adr_o <= own_adr;
                        rl.reload_bus_req_o <= 1'b1;
                        state               <= ACCESS;
                    end else begin
                        last      <= rl.owner_o;
                        rl.busy_o <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mor1kx_tlb_reload_arbiter.sv
// tb_mor1kx_tlb_reload_arbiter: directed checks of grant, locking, round robin, errors, watchdog and reset
module tb_mor1kx_tlb_reload_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   iack = 0;
    int   dack = 0;

    always #5 clk = ~clk;

    mor1kx_tlb_reload_arbiter_if #(.OW(32)) rl ();

    mor1kx_tlb_reload_arbiter #(
        .OPTION_OPERAND_WIDTH  (32),
        .FEATURE_RELOAD_TIMEOUT("ENABLED"),
        .OPTION_TIMEOUT_WIDTH  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rl (rl)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        iack += int'(rl.immu_reload_ack_o);
        dack += int'(rl.dmmu_reload_ack_o);
    endtask

    task automatic serve(input int n, input logic a, input logic e, input logic [31:0] d);
        for (int i = 0; i < n; i++) begin
            check("breq_hold", 32'(rl.reload_bus_req_o), 1);
            if (i == n - 1) begin
                rl.reload_bus_ack_i = a;
                rl.reload_bus_err_i = e;
                rl.reload_bus_dat_i = d;
            end
            tick();
        end
        rl.reload_bus_ack_i = 1'b0;
        rl.reload_bus_err_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rl.immu_reload_req_i = 1'b0;
        rl.dmmu_reload_req_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rl.immu_reload_req_i  = 1'b0;
        rl.immu_reload_addr_i = '0;
        rl.dmmu_reload_req_i  = 1'b0;
        rl.dmmu_reload_addr_i = '0;
        rl.reload_bus_ack_i   = 1'b0;
        rl.reload_bus_err_i   = 1'b0;
        rl.reload_bus_dat_i   = '0;
        do_reset();
        check("rst_breq", 32'(rl.reload_bus_req_o), 0);
        check("rst_busy", 32'(rl.busy_o), 0);
        check("rst_owner", 32'(rl.owner_o), 0);
        check("rst_adr", rl.reload_bus_adr_o, 0);
        check("rst_idata", rl.immu_reload_data_o, 0);
        check("rst_acks", {30'd0, rl.immu_reload_ack_o, rl.dmmu_reload_ack_o}, 0);
        check("rst_errs", {30'd0, rl.immu_reload_err_o, rl.dmmu_reload_err_o}, 0);

        // single IMMU read, bus answers in the third ACCESS cycle
        rl.immu_reload_req_i  = 1'b1;
        rl.immu_reload_addr_i = 'h1000_0040;
        tick();
        check("t1_busy", 32'(rl.busy_o), 1);
        check("t1_owner", 32'(rl.owner_o), 0);
        check("t1_adr", rl.reload_bus_adr_o, 'h1000_0040);
        serve(3, 1'b1, 1'b0, 'hABCD_0401);
        check("t1_breq_off", 32'(rl.reload_bus_req_o), 0);
        check("t1_iack", 32'(rl.immu_reload_ack_o), 1);
        check("t1_idata", rl.immu_reload_data_o, 'hABCD_0401);
        check("t1_ierr", 32'(rl.immu_reload_err_o), 0);
        tick();
        check("t1_iack_pulse", 32'(rl.immu_reload_ack_o), 0);
        rl.immu_reload_req_i = 1'b0;
        tick();
        check("t1_idle", 32'(rl.busy_o), 0);
        check("t1_iack_cnt", 32'(iack), 1);
        check("t1_dack_cnt", 32'(dack), 0);
        rl.reload_bus_ack_i = 1'b1;
        rl.reload_bus_dat_i = 'h0BAD_0BAD;
        tick();
        rl.reload_bus_ack_i = 1'b0;
        tick();
        check("stray_ack_busy", 32'(rl.busy_o), 0);
        check("stray_ack_data", rl.immu_reload_data_o, 'hABCD_0401);
        check("stray_ack_cnt", 32'(iack), 1);

        // two-access IMMU walk with exactly two idle bus cycles between accesses
        rl.immu_reload_req_i  = 1'b1;
        rl.immu_reload_addr_i = 'h100;
        tick();
        check("t2_adr0", rl.reload_bus_adr_o, 'h100);
        serve(1, 1'b1, 1'b0, 'h1111_0100);
        check("t2_ack0", 32'(rl.immu_reload_ack_o), 1);
        check("t2_gap0", 32'(rl.reload_bus_req_o), 0);
        tick();
        check("t2_gap1", 32'(rl.reload_bus_req_o), 0);
        check("t2_owner_chk", 32'(rl.owner_o), 0);
        rl.immu_reload_addr_i = 'h2040;
        tick();
        check("t2_breq1", 32'(rl.reload_bus_req_o), 1);
        check("t2_adr1", rl.reload_bus_adr_o, 'h2040);
        serve(2, 1'b1, 1'b0, 'h2222_2040);
        check("t2_data1", rl.immu_reload_data_o, 'h2222_2040);
        tick();
        rl.immu_reload_req_i = 1'b0;
        tick();
        check("t2_idle", 32'(rl.busy_o), 0);
        check("t2_owner", 32'(rl.owner_o), 0);

        // simultaneous requests: IMMU first, DMMU locked out until IMMU's walk ends
        do_reset();
        rl.immu_reload_req_i  = 1'b1;
        rl.immu_reload_addr_i = 'h300;
        rl.dmmu_reload_req_i  = 1'b1;
        rl.dmmu_reload_addr_i = 'h400;
        tick();
        check("t3_owner0", 32'(rl.owner_o), 0);
        check("t3_adr0", rl.reload_bus_adr_o, 'h300);
        serve(1, 1'b1, 1'b0, 'h11);
        check("t3_acks0", {30'd0, rl.immu_reload_ack_o, rl.dmmu_reload_ack_o}, 2);
        tick();
        rl.immu_reload_addr_i = 'h304;
        tick();
        check("t3_lock_owner", 32'(rl.owner_o), 0);
        check("t3_lock_adr", rl.reload_bus_adr_o, 'h304);
        serve(1, 1'b1, 1'b0, 'h12);
        tick();
        rl.immu_reload_req_i = 1'b0;
        tick();
        check("t3_idle", 32'(rl.busy_o), 0);
        rl.immu_reload_req_i  = 1'b1;
        rl.immu_reload_addr_i = 'h500;
        tick();
        check("t3_rr_owner", 32'(rl.owner_o), 1);
        check("t3_rr_adr", rl.reload_bus_adr_o, 'h400);
        serve(1, 1'b1, 1'b0, 'h22);
        check("t3_acks1", {30'd0, rl.immu_reload_ack_o, rl.dmmu_reload_ack_o}, 1);
        check("t3_ddata", rl.dmmu_reload_data_o, 'h22);
        check("t3_idata", rl.immu_reload_data_o, 'h12);
        tick();
        rl.dmmu_reload_req_i = 1'b0;
        tick();
        tick();
        check("t3_next_owner", 32'(rl.owner_o), 0);
        check("t3_next_adr", rl.reload_bus_adr_o, 'h500);
        serve(1, 1'b1, 1'b0, 'h33);
        tick();
        rl.immu_reload_req_i = 1'b0;
        tick();

        // error and ack together: error reported, data kept; a later good read clears err
        rl.immu_reload_req_i  = 1'b1;
        rl.immu_reload_addr_i = 'h600;
        tick();
        serve(2, 1'b1, 1'b1, 'hDEAD_BEEF);
        check("t4_ack", 32'(rl.immu_reload_ack_o), 1);
        check("t4_err", 32'(rl.immu_reload_err_o), 1);
        check("t4_data", rl.immu_reload_data_o, 'h33);
        tick();
        rl.immu_reload_addr_i = 'h604;
        tick();
        serve(1, 1'b1, 1'b0, 'h44);
        check("t4_err_clr", 32'(rl.immu_reload_err_o), 0);
        check("t4_data2", rl.immu_reload_data_o, 'h44);
        tick();
        rl.immu_reload_req_i = 1'b0;
        tick();

        // watchdog: 15 ACCESS cycles with no answer, then err, and the walk goes on
        rl.dmmu_reload_req_i  = 1'b1;
        rl.dmmu_reload_addr_i = 'h700;
        tick();
        check("t5_owner", 32'(rl.owner_o), 1);
        for (int i = 0; i < 15; i++) begin
            check("t5_breq", 32'(rl.reload_bus_req_o), 1);
            tick();
        end
        check("t5_breq_off", 32'(rl.reload_bus_req_o), 0);
        check("t5_ack", 32'(rl.dmmu_reload_ack_o), 1);
        check("t5_err", 32'(rl.dmmu_reload_err_o), 1);
        check("t5_data", rl.dmmu_reload_data_o, 'h22);
        tick();
        rl.dmmu_reload_addr_i = 'h704;
        tick();
        check("t5_cont_adr", rl.reload_bus_adr_o, 'h704);
        serve(1, 1'b1, 1'b0, 'h55);
        check("t5_cont_err", 32'(rl.dmmu_reload_err_o), 0);
        check("t5_cont_data", rl.dmmu_reload_data_o, 'h55);
        tick();
        rl.dmmu_reload_req_i = 1'b0;
        tick();

        // reset in the middle of an access kills it without a response
        iack = 0;
        dack = 0;
        rl.immu_reload_req_i  = 1'b1;
        rl.immu_reload_addr_i = 'h800;
        tick();
        check("t6_breq", 32'(rl.reload_bus_req_o), 1);
        rst = 1'b1;
        rl.immu_reload_req_i = 1'b0;
        tick();
        check("t6_rst_breq", 32'(rl.reload_bus_req_o), 0);
        check("t6_rst_busy", 32'(rl.busy_o), 0);
        rst = 1'b0;
        tick();
        tick();
        check("t6_no_ack", 32'(iack + dack), 0);
        rl.dmmu_reload_req_i  = 1'b1;
        rl.dmmu_reload_addr_i = 'h900;
        tick();
        check("t6_owner", 32'(rl.owner_o), 1);
        check("t6_adr", rl.reload_bus_adr_o, 'h900);
        serve(1, 1'b1, 1'b0, 'h66);
        check("t6_dack", 32'(rl.dmmu_reload_ack_o), 1);
        check("t6_ddata", rl.dmmu_reload_data_o, 'h66);
        tick();
        rl.dmmu_reload_req_i = 1'b0;
        tick();
        check("t6_idle", 32'(rl.busy_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
